pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 152 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL start-up supervisor: pulses the PLL reset, waits for a stable synchronized
// lock, then releases the core reset; retries on timeout and latches a failure.
module pll_lock_supervisor #(
   parameter int unsigned RESET_CYCLES  = 12,
   parameter int unsigned LOCK_TIMEOUT  = 1200,
   parameter int unsigned STABLE_CYCLES = 64,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic       REFERENCECLK,
   input  logic       RESET,
   input  logic       LOCK,
   output logic       PLLRESETB,
   output logic       CORERESET,
   output logic       READY,
   output logic       ERROR,
   output logic [7:0] RELOCKCOUNT
);

   localparam int unsigned MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [RTY_W-1:0]   r_retry;
   logic [RTY_W-1:0]   w_retry_nxt;
   logic [7:0]         r_relock;
   logic [7:0]         w_relock_nxt;
   logic               r_sync1;
   logic               r_lock_s;
   logic               r_pllresetb;
   logic               r_corereset;
   logic               r_ready;
   logic               r_error;
   logic               w_pllresetb;
   logic               w_corereset;
   logic               w_ready;
   logic               w_error;

   // Two-flop synchronizer; r_lock_s is the only view of LOCK used by the FSM.
   always_ff @(posedge REFERENCECLK) begin
      if (RESET) begin
         r_sync1  <= 1'b0;
         r_lock_s <= 1'b0;
      end else begin
         r_sync1  <= LOCK;
         r_lock_s <= r_sync1;
      end
   end

   always_ff @(posedge REFERENCECLK) begin
      if (RESET) begin
         r_state     <= S_HOLD;
         r_cnt       <= '0;
         r_retry     <= '0;
         r_relock    <= '0;
         r_pllresetb <= 1'b0;
         r_corereset <= 1'b1;
         r_ready     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_nxt;
         r_retry     <= w_retry_nxt;
         r_relock    <= w_relock_nxt;
         r_pllresetb <= w_pllresetb;
         r_corereset <= w_corereset;
         r_ready     <= w_ready;
         r_error     <= w_error;
      end
   end

   // Next state, shared cycle counter, retry/relock bookkeeping and next-state output decode.
   always_comb begin
      w_next       = r_state;
      w_cnt_nxt    = r_cnt;
      w_retry_nxt  = r_retry;
      w_relock_nxt = r_relock;
      w_pllresetb  = 1'b0;
      w_corereset  = 1'b1;
      w_ready      = 1'b0;
      w_error      = 1'b0;

      case (r_state)
         S_HOLD: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(RESET_CYCLES - 1)) w_next = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_lock_s) begin
               w_next = S_STABLE;
            end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
               if (r_retry < RTY_W'(MAX_RETRIES)) begin
                  w_next      = S_HOLD;
                  w_retry_nxt = r_retry + RTY_W'(1);
               end else begin
                  w_next = S_FAIL;
               end
            end
         end
         S_STABLE: begin
            // Lock loss wins over a completing count.
            if (!r_lock_s) begin
               w_next = S_WAIT_LOCK;
            end else if (r_cnt == CNT_W'(STABLE_CYCLES)) begin
               w_next      = S_RUN;
               w_retry_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!r_lock_s) begin
               w_next = S_HOLD;
               if (r_relock != 8'hFF) w_relock_nxt = r_relock + 8'd1;
            end
         end
         S_FAIL: begin
            w_next = S_FAIL;
         end
         default: begin
            w_next = S_HOLD;
         end
      endcase

      if (w_next != r_state) w_cnt_nxt = '0;

      w_pllresetb = (w_next == S_WAIT_LOCK) || (w_next == S_STABLE) || (w_next == S_RUN);
      w_corereset = (w_next != S_RUN);
      w_ready     = (w_next == S_RUN);
      w_error     = (w_next == S_FAIL);
   end

   assign PLLRESETB   = r_pllresetb;
   assign CORERESET   = r_corereset;
   assign READY       = r_ready;
   assign ERROR       = r_error;
   assign RELOCKCOUNT = r_relock;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, multi-cycle corner sequences,
// and random LOCK/RESET traffic against an elapsed-time reference model.
module tb_pll_lock_supervisor;

   localparam int RESET_CYCLES  = 12;
   localparam int LOCK_TIMEOUT  = 1200;
   localparam int STABLE_CYCLES = 64;
   localparam int MAX_RETRIES   = 3;

   localparam int M_HOLD   = 0;
   localparam int M_WAIT   = 1;
   localparam int M_STABLE = 2;
   localparam int M_RUN    = 3;
   localparam int M_FAIL   = 4;

   logic       clk;
   logic       rst;
   logic       lock;
   logic       pllresetb;
   logic       corereset;
   logic       ready;
   logic       error;
   logic [7:0] relock;

   int n_assert = 0;
   int n_fail   = 0;

   pll_lock_supervisor #(
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
   ) u_dut (
      .REFERENCECLK(clk),
      .RESET       (rst),
      .LOCK        (lock),
      .PLLRESETB   (pllresetb),
      .CORERESET   (corereset),
      .READY       (ready),
      .ERROR       (error),
      .RELOCKCOUNT (relock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase plus edge of entry; decisions use time elapsed in the phase.
   int   m_edge    = 0;
   int   m_mode    = M_HOLD;
   int   m_entry   = 0;
   int   m_retries = 0;
   int   m_relock  = 0;
   bit   m_valid   = 0;
   bit   m_pipe [2];

   function automatic logic [11:0] pack(input bit p, input bit c, input bit r, input bit e,
                                        input int rc);
      logic [7:0] rc8;
      rc8 = 8'(rc);
      return {p, c, r, e, rc8};
   endfunction

   function automatic logic [11:0] dut_out();
      return {pllresetb, corereset, ready, error, relock};
   endfunction

   function automatic logic [11:0] model_out();
      bit on;
      on = (m_mode == M_WAIT) || (m_mode == M_STABLE) || (m_mode == M_RUN);
      return pack(on, m_mode != M_RUN, m_mode == M_RUN, m_mode == M_FAIL, m_relock);
   endfunction

   task automatic model_step(input bit r, input bit lk);
      bit ls;
      int el;
      int nm;
      m_edge++;
      if (r) begin
         m_mode    = M_HOLD;
         m_entry   = m_edge;
         m_retries = 0;
         m_relock  = 0;
         m_pipe[0] = 0;
         m_pipe[1] = 0;
         m_valid   = 1;
         return;
      end
      ls        = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = lk;
      el = m_edge - m_entry;
      nm = m_mode;
      case (m_mode)
         M_HOLD:   if (el == RESET_CYCLES) nm = M_WAIT;
         M_WAIT: begin
            if (ls) nm = M_STABLE;
            else if (el == LOCK_TIMEOUT) begin
               if (m_retries < MAX_RETRIES) begin
                  m_retries++;
                  nm = M_HOLD;
               end else nm = M_FAIL;
            end
         end
         M_STABLE: begin
            if (!ls) nm = M_WAIT;
            else if (el > STABLE_CYCLES) begin
               nm = M_RUN;
               m_retries = 0;
            end
         end
         M_RUN: begin
            if (!ls) begin
               nm = M_HOLD;
               if (m_relock < 255) m_relock++;
            end
         end
         default: nm = M_FAIL;
      endcase
      if (nm != m_mode) begin
         m_mode  = nm;
         m_entry = m_edge;
      end
   endtask

   task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, m_edge);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int exp);
      n_assert++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(rst, lock);
      @(negedge clk);
      if (m_valid) check("model", dut_out(), model_out());
   endtask

   typedef struct {
      logic        rst;
      logic        lk;
      int          n;
      logic [11:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [10];

   task automatic apply_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         rst  = vecs[i].rst;
         lock = vecs[i].lk;
         repeat (vecs[i].n) tick();
         check(vecs[i].name, dut_out(), vecs[i].exp);
      end
   endtask

   initial begin
      int base, rel, rises, fall_e, bad_len, err_e, ready_seen, ready_e, got;
      logic prev;

      // Row 0's single edge is edge 0; later rows count edges from there.
      vecs[0] = '{1'b1, 1'b1, 1,  pack(0, 1, 0, 0, 0), "reset_values"};
      vecs[1] = '{1'b0, 1'b1, 11, pack(0, 1, 0, 0, 0), "hold_edge11"};
      vecs[2] = '{1'b0, 1'b1, 1,  pack(1, 1, 0, 0, 0), "pllresetb_rise_edge12"};
      vecs[3] = '{1'b0, 1'b1, 65, pack(1, 1, 0, 0, 0), "not_ready_edge77"};
      vecs[4] = '{1'b0, 1'b1, 1,  pack(1, 0, 1, 0, 0), "ready_edge78"};
      vecs[5] = '{1'b0, 1'b0, 1,  pack(1, 0, 1, 0, 0), "glitch_edge1"};
      vecs[6] = '{1'b0, 1'b1, 1,  pack(1, 0, 1, 0, 0), "glitch_edge2"};
      vecs[7] = '{1'b0, 1'b1, 1,  pack(0, 1, 0, 0, 1), "glitch_hold_edge3"};
      vecs[8] = '{1'b0, 1'b1, 77, pack(1, 1, 0, 0, 1), "relock_not_ready"};
      vecs[9] = '{1'b0, 1'b1, 1,  pack(1, 0, 1, 0, 1), "relock_ready_78"};

      rst  = 1'b1;
      lock = 1'b1;

      // Clean start, RUN, then a one-cycle lock glitch and full re-sequence.
      apply_rows(0, 9);

      // Reset mid-STABLE, then the clean start must repeat.
      apply_rows(0, 2);
      repeat (30) tick();
      apply_rows(0, 4);

      // LOCK stuck low: four 12-cycle PLL reset pulses then FAIL at edge 4848.
      rst = 1'b1; lock = 1'b0; tick(); rst = 1'b0;
      base = m_edge; rises = 0; fall_e = 0; bad_len = 0; err_e = -1; ready_seen = 0;
      prev = pllresetb;
      for (int k = 0; k < 4900; k++) begin
         tick();
         rel = m_edge - base;
         if (!prev && pllresetb) begin
            rises++;
            if (rel - fall_e != RESET_CYCLES) bad_len++;
         end
         if (prev && !pllresetb) fall_e = rel;
         if (error && err_e < 0) err_e = rel;
         if (ready) ready_seen = 1;
         prev = pllresetb;
      end
      check_int("stuck_pulse_count", rises, 4);
      check_int("stuck_pulse_len_bad", bad_len, 0);
      check_int("stuck_error_edge", err_e, 4848);
      check_int("stuck_ready_seen", ready_seen, 0);
      check("stuck_final", dut_out(), pack(0, 1, 0, 1, 0));

      // Reset out of FAIL.
      apply_rows(0, 4);

      // Lock drop inside STABLE: back to WAIT_LOCK, READY 65 edges after re-entering STABLE.
      apply_rows(0, 2);
      base = m_edge - RESET_CYCLES;
      repeat (41) tick();
      lock = 1'b0;
      repeat (3) tick();
      check("stable_drop_wait", dut_out(), pack(1, 1, 0, 0, 0));
      lock = 1'b1;
      ready_e = -1;
      for (int k = 0; k < 120 && ready_e < 0; k++) begin
         tick();
         if (ready) ready_e = m_edge - base;
      end
      check_int("stable_drop_ready_edge", ready_e, 124);

      // Same drop but LOCK then stays low: FAIL timing shows no retry was consumed.
      apply_rows(0, 2);
      base = m_edge - RESET_CYCLES;
      repeat (41) tick();
      lock = 1'b0;
      err_e = -1;
      for (int k = 0; k < 5000 && err_e < 0; k++) begin
         tick();
         if (error) err_e = m_edge - base;
      end
      check_int("no_retry_error_edge", err_e, 4892);

      // 300 lock losses in RUN: RELOCKCOUNT saturates at 255.
      apply_rows(0, 4);
      for (int i = 0; i < 300; i++) begin
         lock = 1'b0; tick();
         lock = 1'b1; tick(); tick();
         got = 0;
         for (int k = 0; k < 100 && got == 0; k++) begin
            tick();
            if (ready) got = 1;
         end
         check_int("relock_ready_return", got, 1);
      end
      check_int("relock_saturated", int'(relock), 255);

      // Random LOCK segments with occasional RESET, checked each edge by the model.
      for (int s = 0; s < 60; s++) begin
         int len;
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end
         lock = ($urandom_range(0, 3) != 0);
         if (lock) len = int'($urandom_range(1, 150));
         else if ($urandom_range(0, 9) == 0) len = int'($urandom_range(1150, 1300));
         else len = int'($urandom_range(1, 6));
         repeat (len) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
